// File: rtl/cbs_credit_gate.sv
// Credit-based shaper gate for one traffic class, between a class queue and an arbiter input.
// Latency: zero; data, keep and last pass through combinationally with no buffering.
// Backpressure: a new frame starts only when credit >= 0; once started, the frame passes to tlast.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   enable                    1 = shaping, 0 = transparent pass-through (credit forced to 0)
//   idle_slope, send_slope    unsigned credit gain per eligible cycle / loss per transmitted byte
//   hi_credit, lo_credit      signed clamp limits applied to every credit update
//   s_axis_*                  upstream AXI-Stream slave (from class queue)
//   m_axis_*                  downstream AXI-Stream master (to arbiter)
//   credit                    registered signed credit
//   gate_open                 1 when a new frame may start (or a frame is in flight)
module cbs_credit_gate #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int SLOPE_WIDTH        = 16,
  parameter int CREDIT_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [SLOPE_WIDTH-1:0]        idle_slope,
  input  logic [SLOPE_WIDTH-1:0]        send_slope,
  input  logic [CREDIT_WIDTH-1:0]       hi_credit,
  input  logic [CREDIT_WIDTH-1:0]       lo_credit,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [CREDIT_WIDTH-1:0]       credit,
  output logic                          gate_open
);

  localparam int BW = $clog2(C_AXIS_TKEEP_WIDTH + 1);   // byte-count width
  localparam int PW = SLOPE_WIDTH + BW;                 // debit product width
  localparam int EW = CREDIT_WIDTH + 1;                 // extended arithmetic width

  typedef enum logic {IDLE, XMIT} state_e;

  state_e                   state_q, state_d;
  logic [CREDIT_WIDTH-1:0]  credit_q, credit_d;

  logic                     gate;
  logic                     beat;
  logic                     credit_neg;
  logic                     credit_pos;
  logic [BW-1:0]            bytes;
  logic [PW-1:0]            debit;
  logic signed [EW-1:0]     cur_x, debit_x, idle_x, lo_x, hi_x, raw;

  // Gate depends only on registered state/credit and enable, never on slopes or limits.
  // Holding rstn in the term forces both handshakes low while in reset.
  assign credit_neg = credit_q[CREDIT_WIDTH-1];
  assign credit_pos = !credit_neg && (credit_q != '0);
  assign gate       = rstn && ((state_q == XMIT) || !enable || !credit_neg);

  assign gate_open     = gate;
  assign m_axis_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = m_axis_tready & gate;
  assign beat          = s_axis_tvalid & s_axis_tready;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign credit        = credit_q;

  always_comb begin
    bytes = '0;
    for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
      bytes = bytes + BW'(s_axis_tkeep[i]);
    end
  end

  // Extended width guarantees that neither debit nor idle gain can wrap before clamping.
  assign debit   = PW'(send_slope) * PW'(bytes);
  assign cur_x   = {credit_q[CREDIT_WIDTH-1], credit_q};
  assign debit_x = {{(EW-PW){1'b0}}, debit};
  assign idle_x  = {{(EW-SLOPE_WIDTH){1'b0}}, idle_slope};
  assign lo_x    = {lo_credit[CREDIT_WIDTH-1], lo_credit};
  assign hi_x    = {hi_credit[CREDIT_WIDTH-1], hi_credit};

  always_comb begin
    raw = cur_x;
    if (!enable) begin
      raw = '0;
    end else if (beat) begin
      raw = cur_x - debit_x;
    end else if ((state_q == IDLE) && !s_axis_tvalid && credit_pos) begin
      // Empty queue: positive credit is not banked.
      raw = '0;
    end else if (s_axis_tvalid || credit_neg || (state_q == XMIT)) begin
      raw = cur_x + idle_x;
    end

    // Clamp every update, including holds, so a raised lo_credit takes effect next cycle.
    if (raw > hi_x) begin
      credit_d = hi_credit;
    end else if (raw < lo_x) begin
      credit_d = lo_credit;
    end else begin
      credit_d = raw[CREDIT_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat && !s_axis_tlast) state_d = XMIT;
      XMIT:    if (beat &&  s_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: tb/tb_cbs_credit_gate.sv
module tb_cbs_credit_gate;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [SW-1:0] idle_slope = '0;
  logic [SW-1:0] send_slope = '0;
  logic [CW-1:0] hi_credit = '0;
  logic [CW-1:0] lo_credit = '0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [CW-1:0] credit;
  logic          gate_open;

  cbs_credit_gate #(
    .C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TKEEP_WIDTH(KW),
    .SLOPE_WIDTH(SW), .CREDIT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable),
    .idle_slope(idle_slope), .send_slope(send_slope),
    .hi_credit(hi_credit), .lo_credit(lo_credit),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .credit(credit), .gate_open(gate_open)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: credit as a plain integer, frame-in-flight as a flag.
  longint mcredit = 0;
  bit     mxmit   = 0;
  bit     mbeat   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [CW-1:0] v);
    return 64'($signed(v));
  endfunction

  // One clock: compare outputs on the falling edge, then advance the model on the rising edge.
  task automatic cyc();
    bit     g;
    longint nc;
    longint lo;
    longint hi;
    @(negedge clk);
    g = rstn && (mxmit || !enable || mcredit >= 0);
    check("gate_open", 64'(gate_open), 64'(g));
    check("m_tvalid", 64'(m_tvalid), 64'(s_tvalid && g));
    check("s_tready", 64'(s_tready), 64'(m_tready && g));
    check("credit", sx(credit), 64'(mcredit));
    check("pass_data", m_tdata, s_tdata);
    check("pass_keep_last", {55'd0, m_tkeep, m_tlast}, {55'd0, s_tkeep, s_tlast});
    @(posedge clk);
    mbeat = s_tvalid && m_tready && g;
    if (!rstn) begin
      mcredit = 0;
      mxmit   = 0;
    end else begin
      lo = longint'($signed(lo_credit));
      hi = longint'($signed(hi_credit));
      if (!enable)
        nc = 0;
      else if (mbeat)
        nc = mcredit - longint'(send_slope) * longint'($countones(s_tkeep));
      else if (!mxmit && !s_tvalid && mcredit > 0)
        nc = 0;
      else if (s_tvalid || mcredit < 0 || mxmit)
        nc = mcredit + longint'(idle_slope);
      else
        nc = mcredit;
      if (nc > hi) nc = hi;
      else if (nc < lo) nc = lo;
      mcredit = nc;
      if (mbeat) mxmit = !s_tlast;
    end
    #1;
  endtask

  // Offer a frame of nb beats; stalls counts cycles before the first beat is accepted.
  task automatic run_frame(input int nb, input logic [KW-1:0] kmid, input logic [KW-1:0] klast,
                           input bit last_flag, output int stalls);
    int done;
    int budget;
    done   = 0;
    budget = 0;
    stalls = 0;
    while (done < nb && budget < 2000) begin
      s_tdata  = {$urandom, $urandom};
      s_tkeep  = (done == nb - 1) ? klast : kmid;
      s_tlast  = (done == nb - 1) && last_flag;
      s_tvalid = 1'b1;
      cyc();
      budget++;
      if (mbeat) done++;
      else if (done == 0) stalls++;
    end
    check("frame_complete", 64'(done), 64'(nb));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic recover();
    int budget;
    budget   = 0;
    s_tvalid = 1'b0;
    while (mcredit != 0 && budget < 2000) begin
      cyc();
      budget++;
    end
    check("recover_credit", sx(credit), 64'd0);
  endtask

  initial begin
    int st;
    int v;
    int k;

    // Reset state with traffic offered.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    #3;
    check("rst_gate", 64'(gate_open), 64'd0);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_credit", sx(credit), 64'd0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    // Two 64-byte frames back to back, one byte per beat.
    enable = 1'b1; idle_slope = 16'd1; send_slope = 16'd3;
    lo_credit = -32'sd1000; hi_credit = 32'sd1000;
    run_frame(64, 8'h01, 8'h01, 1, st);
    check("t1_f1_stalls", 64'(st), 64'd0);
    check("t1_credit_after_f1", sx(credit), -64'sd192);
    run_frame(64, 8'h01, 8'h01, 1, st);
    check("t1_f2_stalls", 64'(st), 64'd192);

    // Same with a tighter lower clamp.
    recover();
    lo_credit = -32'sd100;
    run_frame(64, 8'h01, 8'h01, 1, st);
    check("t2_f1_stalls", 64'(st), 64'd0);
    check("t2_credit_clamped", sx(credit), -64'sd100);
    run_frame(64, 8'h01, 8'h01, 1, st);
    check("t2_f2_stalls", 64'(st), 64'd100);

    // Upper clamp while stalled downstream, then discard on empty queue.
    recover();
    lo_credit = -32'sd1000; hi_credit = 32'sd50;
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tkeep = 8'h01; m_tready = 1'b0;
    for (int i = 0; i < 80; i++) cyc();
    check("t3_credit_sat", sx(credit), 64'sd50);
    s_tvalid = 1'b0; m_tready = 1'b1;
    cyc();
    check("t3_credit_discard", sx(credit), 64'd0);

    // Wide beats: 8 bytes then 5 bytes at send_slope 2.
    hi_credit = 32'sd1000; send_slope = 16'd2;
    s_tvalid = 1'b1; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tdata = {$urandom, $urandom};
    cyc();
    check("t4_credit_beat1", sx(credit), -64'sd16);
    s_tkeep = 8'h1F; s_tlast = 1'b1; s_tdata = {$urandom, $urandom};
    cyc();
    check("t4_credit_final", sx(credit), -64'sd26);
    s_tvalid = 1'b0; s_tlast = 1'b0;

    // Build credit -50, then disable: zeroed and transparent.
    recover();
    run_frame(4, 8'hFF, 8'h01, 1, st);
    check("t5_credit_before", sx(credit), -64'sd50);
    enable = 1'b0; s_tvalid = 1'b1;
    cyc();
    check("t5_credit_zeroed", sx(credit), 64'd0);
    for (int i = 0; i < 30; i++) begin
      m_tready = 1'($urandom);
      s_tlast  = ($urandom_range(0, 3) == 0);
      s_tdata  = {$urandom, $urandom};
      cyc();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;

    // Reset in the middle of a frame with credit -40.
    enable = 1'b1;
    run_frame(3, 8'hFF, 8'h0F, 0, st);
    check("t6_credit_before", sx(credit), -64'sd40);
    s_tvalid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_rst_tready", 64'(s_tready), 64'd0);
    check("t6_rst_credit", sx(credit), 64'd0);
    mcredit = 0; mxmit = 0;
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    run_frame(1, 8'h01, 8'h01, 1, st);
    check("t6_restart_stalls", 64'(st), 64'd0);

    // Randomized traffic and configuration against the model.
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(0, 15) != 0);
      idle_slope = 16'($urandom_range(0, 20));
      send_slope = 16'($urandom_range(0, 10));
      v = $urandom_range(0, 300); lo_credit = -v;
      v = $urandom_range(0, 300); hi_credit = v;
      k = $urandom_range(1, KW);
      s_tkeep  = 8'((16'd1 << k) - 16'd1);
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tlast  = ($urandom_range(0, 3) == 0);
      m_tready = ($urandom_range(0, 3) != 0);
      s_tdata  = {$urandom, $urandom};
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
